// File: rtl/cla_pkg.sv
// Shared opcode, flag-bit and state definitions for the byte-serial CLA sequencer.
package cla_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ADC = 2'd2,
        OP_ACC = 2'd3
    } op_e;

    localparam int unsigned FLAG_C   = 0;
    localparam int unsigned FLAG_V   = 1;
    localparam int unsigned FLAG_Z   = 2;
    localparam int unsigned FLAG_ERR = 3;

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_RES  = 3'd4,
        S_FLG  = 3'd5
    } state_e;

endpackage

// File: rtl/cla_byte_sequencer_if.sv
// Byte-wide valid/ready input and output streams of the CLA sequencer.
interface cla_byte_sequencer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/cla_adder.sv
// Combinational carry-lookahead adder made of 4-bit lookahead groups chained by group carry.
module cla_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned NG = WIDTH / 4;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int unsigned L = 4 * k;
        // Every carry inside the group is computed from the group carry-in directly.
        assign c[L+1] = g[L] | (p[L] & c[L]);
        assign c[L+2] = g[L+1] | (p[L+1] & g[L]) | (p[L+1] & p[L] & c[L]);
        assign c[L+3] = g[L+2] | (p[L+2] & g[L+1]) | (p[L+2] & p[L+1] & g[L])
                      | (p[L+2] & p[L+1] & p[L] & c[L]);
        assign c[L+4] = g[L+3] | (p[L+3] & g[L+2]) | (p[L+3] & p[L+2] & g[L+1])
                      | (p[L+3] & p[L+2] & p[L+1] & g[L])
                      | (p[L+3] & p[L+2] & p[L+1] & p[L] & c[L]);
    end

    assign sum  = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];
endmodule

// File: rtl/cla_byte_sequencer.sv
// Collects opcode and operands byte-serially, runs one CLA operation, streams result and flags.
module cla_byte_sequencer
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_byte_sequencer_if.slave  bus,
    output logic                 busy
);
    localparam int unsigned NB   = WIDTH / 8;
    localparam int unsigned CntW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(NB - 1);

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [NB-1:0][7:0]     a_q, a_d;
    logic [NB-1:0][7:0]     b_q, b_d;
    logic [NB-1:0][7:0]     r_q, r_d;
    logic                   carry_q, carry_d;
    logic [7:0]             flags_q, flags_d;
    op_e                    op_q, op_d;

    logic [WIDTH-1:0] a_flat;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             cin;
    logic             cout;

    assign a_flat = a_q;

    always_comb begin
        b_eff = (op_q == OP_SUB) ? ~b_q : b_q;
        case (op_q)
            OP_SUB:  cin = 1'b1;
            OP_ADC:  cin = carry_q;
            default: cin = 1'b0;
        endcase
    end

    cla_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (a_flat),
        .b    (b_eff),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        a_d           = a_q;
        b_d           = b_q;
        r_d           = r_q;
        carry_d       = carry_q;
        flags_d       = flags_q;
        op_d          = op_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = 8'h00;
        busy          = 1'b1;

        case (state_q)
            S_OP: begin
                busy         = 1'b0;
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    cnt_d = '0;
                    if (bus.in_data[7:2] != 6'd0) begin
                        // Illegal opcode: no operands, R and stored carry left untouched.
                        flags_d           = 8'h00;
                        flags_d[FLAG_ERR] = 1'b1;
                        state_d           = S_FLG;
                    end else begin
                        op_d = op_e'(bus.in_data[1:0]);
                        if (op_d == OP_ACC) begin
                            a_d     = r_q;
                            state_d = S_B;
                        end else begin
                            state_d = S_A;
                        end
                    end
                end
            end
            S_A: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    a_d[cnt_q] = bus.in_data;
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        state_d = S_B;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            S_B: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    b_d[cnt_q] = bus.in_data;
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        state_d = S_EXEC;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            S_EXEC: begin
                r_d             = sum;
                carry_d         = cout;
                flags_d         = 8'h00;
                flags_d[FLAG_C] = cout;
                flags_d[FLAG_V] = (a_flat[WIDTH-1] == b_eff[WIDTH-1])
                                && (sum[WIDTH-1] != a_flat[WIDTH-1]);
                flags_d[FLAG_Z] = (sum == '0);
                cnt_d           = '0;
                state_d         = S_RES;
            end
            S_RES: begin
                bus.out_valid = 1'b1;
                bus.out_data  = r_q[cnt_q];
                if (bus.out_ready) begin
                    if (cnt_q == CntLast) begin
                        state_d = S_FLG;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            S_FLG: begin
                bus.out_valid = 1'b1;
                bus.out_data  = flags_q;
                if (bus.out_ready) begin
                    state_d = S_OP;
                end
            end
            default: state_d = S_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OP;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            flags_q <= 8'h00;
            op_q    <= OP_ADD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            carry_q <= carry_d;
            flags_q <= flags_d;
            op_q    <= op_d;
        end
    end
endmodule
